// File: rtl/drum_grid_solver_if.sv
// Host-side bundle for the drum grid solver: run control, initial-condition load and per-step sample.
// The host drives through master; the solver sits on slave.
interface drum_grid_solver_if #(
  parameter int ROWS   = 24,
  parameter int COLS   = 24,
  parameter int DATA_W = 18,
  parameter int STEP_W = 16,
  parameter int AW     = $clog2(ROWS * COLS)
);
  logic              enable;
  logic [DATA_W-1:0] rho;
  logic [STEP_W-1:0] num_steps;
  logic              start;
  logic              init_we;
  logic [AW-1:0]     init_addr;
  logic [DATA_W-1:0] init_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic [STEP_W-1:0] step_idx;

  modport master (
    output enable, rho, num_steps, start, init_we, init_addr, init_data,
    input  busy, done, sample_out, sample_valid, step_idx
  );

  modport slave (
    input  enable, rho, num_steps, start, init_we, init_addr, init_data,
    output busy, done, sample_out, sample_valid, step_idx
  );
endinterface

// File: rtl/drum_grid_solver.sv
// Time-stepped 2-D wave solver: one node per cycle through a read / compute / write-back pipeline,
// ping-ponging between two grid banks and emitting the middle-node value after every step.
module drum_grid_solver #(
  parameter int ROWS       = 24,
  parameter int COLS       = 24,
  parameter int DATA_W     = 18,
  parameter int DAMP_SHIFT = 10,
  parameter int STEP_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  drum_grid_solver_if.slave bus
);
  localparam int N   = ROWS * COLS;
  localparam int AW  = $clog2(N);
  localparam int RW  = $clog2(ROWS);
  localparam int CW  = $clog2(COLS);
  localparam int MID = (ROWS / 2) * COLS + COLS / 2;
  // Wide enough that rho*lap and the damping sums never overflow before the final saturate.
  localparam int TW  = 2 * DATA_W + 6;
  localparam logic signed [TW-1:0] MAXV = (TW'(1) <<< (DATA_W - 1)) - TW'(1);
  localparam logic signed [TW-1:0] MINV = ~MAXV;

  typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, SWAP, DONE} state_e;

  function automatic logic signed [TW-1:0] sx(input logic signed [DATA_W-1:0] v);
    return {{(TW - DATA_W){v[DATA_W-1]}}, v};
  endfunction

  state_e                   state_q;
  logic                     bank_q;
  logic signed [DATA_W-1:0] mem_q [2][N];
  logic [AW-1:0]            k_q;
  logic [RW-1:0]            r_q;
  logic [CW-1:0]            c_q;
  logic                     drain_q;
  logic signed [DATA_W-1:0] rho_q;
  logic [STEP_W-1:0]        nsteps_q, step_q;
  logic                     busy_q, done_q, sv_q;
  logic [DATA_W-1:0]        sample_q;
  logic [2:1]               vld_pipe_q;
  logic [AW-1:0]            s1_k_q, s2_k_q;
  logic signed [DATA_W-1:0] s1_u_q, s1_up_q, s2_un_q;
  logic signed [TW-1:0]     s1_nsum_q;

  logic [AW-1:0]            kn, ks, ke, kw;
  logic signed [TW-1:0]     nsum_d;
  logic signed [TW-1:0]     u_w, up_w, lap_w, prod_w, tmp_w, res_w;
  logic signed [DATA_W-1:0] unext_d;
  logic [STEP_W-1:0]        step_nx;
  logic                     issue;

  assign issue   = (state_q == SWEEP);
  assign step_nx = step_q + STEP_W'(1);

  // S0: neighbourhood of k from CUR; off-grid neighbours contribute zero.
  always_comb begin
    kn = k_q - AW'(COLS);
    ks = k_q + AW'(COLS);
    kw = k_q - AW'(1);
    ke = k_q + AW'(1);
    nsum_d = '0;
    if (r_q != '0)             nsum_d = nsum_d + sx(mem_q[bank_q][kn]);
    if (r_q != RW'(ROWS - 1))  nsum_d = nsum_d + sx(mem_q[bank_q][ks]);
    if (c_q != '0)             nsum_d = nsum_d + sx(mem_q[bank_q][kw]);
    if (c_q != CW'(COLS - 1))  nsum_d = nsum_d + sx(mem_q[bank_q][ke]);
  end

  // S1: damped leapfrog update, saturated back to DATA_W.
  always_comb begin
    u_w    = sx(s1_u_q);
    up_w   = sx(s1_up_q);
    lap_w  = s1_nsum_q - (u_w <<< 2);
    prod_w = sx(rho_q) * lap_w;
    tmp_w  = (prod_w >>> (DATA_W - 1)) + (u_w <<< 1) - up_w + (up_w >>> DAMP_SHIFT);
    res_w  = tmp_w - (tmp_w >>> DAMP_SHIFT);
    if (res_w > MAXV)      unext_d = MAXV[DATA_W-1:0];
    else if (res_w < MINV) unext_d = MINV[DATA_W-1:0];
    else                   unext_d = res_w[DATA_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bank_q     <= 1'b0;
      mem_q      <= '{default: '0};
      k_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      drain_q    <= 1'b0;
      rho_q      <= '0;
      nsteps_q   <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sv_q       <= 1'b0;
      sample_q   <= '0;
      vld_pipe_q <= '0;
      s1_k_q     <= '0;
      s1_u_q     <= '0;
      s1_up_q    <= '0;
      s1_nsum_q  <= '0;
      s2_k_q     <= '0;
      s2_un_q    <= '0;
    end else if (!bus.enable) begin
      done_q <= 1'b0;
      sv_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      sv_q       <= 1'b0;
      vld_pipe_q <= {vld_pipe_q[1], issue};
      s1_k_q     <= k_q;
      s1_u_q     <= mem_q[bank_q][k_q];
      s1_up_q    <= mem_q[~bank_q][k_q];
      s1_nsum_q  <= nsum_d;
      s2_k_q     <= s1_k_q;
      s2_un_q    <= unext_d;
      // CUR is never written during a sweep, so write-back into PREV cannot disturb pending reads.
      if (vld_pipe_q[2]) mem_q[~bank_q][s2_k_q] <= s2_un_q;

      case (state_q)
        IDLE: begin
          if (bus.init_we && int'(bus.init_addr) < N) begin
            mem_q[0][bus.init_addr] <= bus.init_data;
            mem_q[1][bus.init_addr] <= bus.init_data;
          end
          if (bus.start) begin
            rho_q    <= bus.rho;
            nsteps_q <= bus.num_steps;
            step_q   <= '0;
            busy_q   <= 1'b1;
            k_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            state_q  <= (bus.num_steps == '0) ? DONE : SWEEP;
          end
        end
        SWEEP: begin
          k_q <= k_q + AW'(1);
          if (c_q == CW'(COLS - 1)) begin
            c_q <= '0;
            r_q <= r_q + RW'(1);
          end else begin
            c_q <= c_q + CW'(1);
          end
          if (k_q == AW'(N - 1)) begin
            drain_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) state_q <= SWAP;
        end
        SWAP: begin
          bank_q   <= ~bank_q;
          sample_q <= mem_q[~bank_q][MID];
          sv_q     <= 1'b1;
          step_q   <= step_nx;
          k_q      <= '0;
          r_q      <= '0;
          c_q      <= '0;
          state_q  <= (step_nx == nsteps_q) ? DONE : SWEEP;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sv_q;
  assign bus.step_idx     = step_q;
endmodule

// File: tb/tb_drum_grid_solver.sv
// Randomized bench for the 4x4 drum solver against a whole-grid arithmetic model of the wave update.
module tb_drum_grid_solver;
  localparam int ROWS = 4, COLS = 4, DW = 18, DS = 10, SW = 16;
  localparam int N = ROWS * COLS, MID = 10, AW = 4, PER = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  drum_grid_solver_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .STEP_W(SW)) bus ();

  drum_grid_solver #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .DAMP_SHIFT(DS), .STEP_W(SW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int nchk = 0;
  int nerr = 0;
  longint cur [N];
  longint prv [N];

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sat(input longint v);
    if (v > 131071) return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint s18(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  // One time step of the membrane: new CUR from CUR/PREV, old CUR becomes PREV.
  task automatic model_step(input longint rho);
    longint nx [N];
    for (int k = 0; k < N; k++) begin
      int r = k / COLS;
      int c = k % COLS;
      longint nb = 0, lap, tmp;
      if (r > 0)        nb += cur[k - COLS];
      if (r < ROWS - 1) nb += cur[k + COLS];
      if (c > 0)        nb += cur[k - 1];
      if (c < COLS - 1) nb += cur[k + 1];
      lap   = nb - 4 * cur[k];
      tmp   = ((rho * lap) >>> (DW - 1)) + 2 * cur[k] - prv[k] + (prv[k] >>> DS);
      nx[k] = sat(tmp - (tmp >>> DS));
    end
    for (int k = 0; k < N; k++) begin
      prv[k] = cur[k];
      cur[k] = nx[k];
    end
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    bus.init_we   = 1'b1;
    bus.init_addr = a[AW-1:0];
    bus.init_data = d;
    tick();
    bus.init_we = 1'b0;
    cur[a] = s18(d);
    prv[a] = s18(d);
  endtask

  task automatic clear_grid();
    for (int a = 0; a < N; a++) load(a, '0);
  endtask

  // Runs ns steps, checking every pulse's timing and value; optional pause and ignored-input noise.
  task automatic run(input logic [DW-1:0] r, input int ns, input int pause_at, input int pause_len,
                     input bit noise, input bit simul);
    int cnt = 0, pulses = 0, exp_edge, done_edge = -1;
    longint rl = s18(r);
    exp_edge = PER + 1 + pause_len;
    bus.rho       = r;
    bus.num_steps = SW'(ns);
    bus.start     = 1'b1;
    if (simul) begin
      int a = $urandom_range(0, N - 1);
      logic [DW-1:0] d = DW'($urandom);
      bus.init_we = 1'b1; bus.init_addr = a[AW-1:0]; bus.init_data = d;
      cur[a] = s18(d); prv[a] = s18(d);
    end
    tick();
    cnt = 1;
    bus.start = 1'b0; bus.init_we = 1'b0;
    bus.rho = DW'($urandom);
    chk("busy_run", bus.busy, 1);
    while (done_edge < 0 && cnt < ns * PER + 60) begin
      if (bus.sample_valid) begin
        model_step(rl);
        pulses++;
        chk("sv_time", cnt, exp_edge);
        chk("sample", s18(bus.sample_out), cur[MID]);
        chk("step_idx", bus.step_idx, pulses);
        exp_edge += PER;
      end
      if (bus.done) begin
        done_edge = cnt;
        chk("done_time", cnt, (ns == 0) ? 2 : exp_edge - PER + 1);
      end
      bus.enable = !(pause_len > 0 && cnt >= pause_at && cnt < pause_at + pause_len);
      if (noise && cnt == 5) begin
        bus.start = 1'b1; bus.init_we = 1'b1;
        bus.init_addr = MID[AW-1:0]; bus.init_data = DW'($urandom);
      end else begin
        bus.start = 1'b0; bus.init_we = 1'b0;
      end
      tick();
      cnt++;
    end
    bus.enable = 1'b1; bus.start = 1'b0; bus.init_we = 1'b0;
    chk("pulses", pulses, ns);
    chk("done_seen", done_edge >= 0, 1);
    chk("busy_after", bus.busy, 0);
    tick();
    chk("done_low", bus.done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bus.enable = 1'b1; bus.start = 1'b0; bus.init_we = 1'b0;
    bus.init_addr = '0; bus.init_data = '0; bus.rho = '0; bus.num_steps = '0;
    for (int k = 0; k < N; k++) begin cur[k] = 0; prv[k] = 0; end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sv", bus.sample_valid, 0);
    chk("rst_sample", bus.sample_out, 0);
    chk("rst_step", bus.step_idx, 0);

    // Zero grid: three silent steps.
    run(18'h08000, 3, 0, 0, 1'b0, 1'b0);
    chk("t1_zero", bus.sample_out, 0);

    // rho=0: damping terms cancel, centre holds.
    clear_grid(); load(MID, 18'h08000);
    run(18'h00000, 2, 0, 0, 1'b0, 1'b0);
    chk("t2_hold", s18(bus.sample_out), 32768);

    // rho=0.25: centre collapses to 0x20 after one step.
    clear_grid(); load(MID, 18'h08000);
    run(18'h08000, 1, 0, 0, 1'b0, 1'b0);
    chk("t3_mid", s18(bus.sample_out), 32);

    // Zero-step run must not swap banks: the next step depends on CUR/PREV order.
    run(18'h08000, 0, 0, 0, 1'b0, 1'b0);
    chk("t4_sample_kept", s18(bus.sample_out), 32);
    run(18'h04000, 1, 0, 0, 1'b0, 1'b0);

    // Pause during the first sweep shifts the pulse by exactly 5 cycles.
    clear_grid(); load(MID, 18'h08000);
    run(18'h00000, 2, 6, 5, 1'b0, 1'b0);
    chk("t5_hold", s18(bus.sample_out), 32768);

    // Randomized grids (including saturating values), rho, step counts and ignored inputs.
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < N; a++)
        load(a, (it < 3) ? DW'($urandom_range(0, 16383) - 8192) : DW'($urandom));
      run(DW'($urandom), $urandom_range(1, 4), (it == 2) ? 3 : 0, (it == 2) ? 4 : 0,
          1'b1, it[0]);
    end

    // Reset mid-sweep clears everything; start/init_we during the run are ignored.
    for (int a = 0; a < N; a++) load(a, DW'($urandom_range(1000, 60000)));
    bus.rho = 18'h08000; bus.num_steps = 16'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_sample", bus.sample_out, 0);
    chk("mrst_step", bus.step_idx, 0);
    for (int k = 0; k < N; k++) begin cur[k] = 0; prv[k] = 0; end
    run(18'h08000, 3, 0, 0, 1'b1, 1'b0);
    chk("mrst_grid", bus.sample_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
